gate_eval_bist: RTL and testbench
=================================

Name: gate_eval_bist

Overview:
- Parametrised, registered successor of the four-input gate cell: CH independent channels, each computing eight = (two|three|four) & ~(one&two).
- Adds built-in self-test for the DFT flow:
  - a 16-bit LFSR drives all channel inputs;
  - a 16-bit MISR compacts the outputs;
  - an FSM sequences the run and compares the result against a golden signature.
- Sits at the leaf of the logic-under-test hierarchy; the test controller drives the bist_* pins.

Parameters:
- CH, 4, channel count, 1..16.
- NPAT, 32, number of BIST patterns applied, 1..65535.
- SEED, 16'hACE1, LFSR load value on BIST start; must be nonzero.
- GOLDEN, 16'h0000, expected MISR signature after a fault-free run.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- one  in  CH  functional input a, one bit per channel.
- two  in  CH  functional input b.
- three  in  CH  functional input c.
- four  in  CH  functional input d.
- eight  out  CH  registered channel results.
- bist_start  in  1  single-cycle start pulse.
- bist_abort  in  1  abandons a run.
- bist_busy  out  1  high in RUN and FLUSH.
- bist_done  out  1  high in DONE.
- bist_pass  out  1  signature match; valid only while bist_done=1.
- signature  out  16  current MISR contents.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - eight=0, misr=0, lfsr=SEED, pattern counter=0.
  - State IDLE; bist_busy=0, bist_done=0, bist_pass=0.
- Core:
  - eight[i] <= (b|c|d) & ~(a&b) per channel, latency exactly 1 clock.
  - In IDLE and DONE, a/b/c/d come from the ports.
  - In RUN, they come from the LFSR: channel i uses a=lfsr[(4i)%16], b=lfsr[(4i+1)%16], c=lfsr[(4i+2)%16], d=lfsr[(4i+3)%16].
  - In FLUSH, the core registers hold; the functional ports are ignored.
- LFSR: Fibonacci, taps 16,14,13,11. Next value = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. Advances only in RUN.
- MISR:
  - Next value = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} XOR zero-extend(eight).
  - Updates in RUN and FLUSH, except the first RUN cycle, whose eight is stale.
  - Result: each of the NPAT responses is absorbed exactly once.
- FSM:
  - IDLE: bist_start -> RUN. On entry lfsr=SEED, misr=0, counter=0.
  - RUN: counter increments each cycle. When counter==NPAT-1 -> FLUSH.
  - FLUSH: one cycle, absorbs the last response -> DONE.
  - DONE:
    - bist_done=1, bist_pass=(misr==GOLDEN); signature holds.
    - bist_start -> RUN, restarting with a fresh seed and clear.
  - bist_abort in RUN or FLUSH -> IDLE. The MISR keeps its partial value; bist_done=0, bist_pass=0.
  - bist_abort in IDLE or DONE: ignored.
  - bist_start in RUN or FLUSH: ignored.
  - bist_start and bist_abort in the same cycle: abort wins.
- Timing: with start sampled at edge 0, bist_done rises after edge NPAT+1. NPAT=1 gives RUN 1 cycle, FLUSH 1 cycle, done after edge 2.
- Reset mid-run: immediate return to the reset values; no partial result is visible.
- bist_pass is combinational from misr and state; every other output is registered.

Decomposition:
- Shared package gate_eval_pkg holds:
  - state enum {IDLE, RUN, FLUSH, DONE};
  - LFSR/MISR width constant 16 and the tap mask 16'hB400;
  - the channel-function macro/function.
- One sub-module, lfsr_misr16, instanced twice: mode=generate for the LFSR, mode=compact for the MISR.
- The channel array is a generate loop in the top level.

Test Plan:
- Functional, CH=1, IDLE: (a,b,c,d) = 1111, 0111, 1101, 1011, 0000, 1001, 0011 -> eight, one cycle later, = 0,1,0,1,0,1,1.
- Reset: assert rst_n=0 asynchronously mid-RUN (e.g. cycle 10 of NPAT=32).
  - Required: eight=0, busy=0, done=0, signature=0 immediately, without a clock edge.
- BIST pass, CH=4, NPAT=32, GOLDEN taken from the bench reference model.
  - Pulse start: busy high for 33 cycles, done after edge 33, pass=1, signature==GOLDEN.
- BIST fail: same run with GOLDEN XOR 16'h0001 -> done=1, pass=0.
- Fault sensitivity: force eight[2] stuck-at-0 in the bench -> pass=0.
- Boundaries, NPAT=1:
  - done after edge 2.
  - abort on the cycle start is sampled -> stays IDLE.
  - abort in FLUSH -> IDLE, done=0.
  - start in DONE -> new run whose signature equals the first.

Source files
------------

// File: rtl/gate_eval_pkg.sv
// Shared types, constants and the channel function for the gate_eval BIST slice.
package gate_eval_pkg;

    localparam int unsigned SIG_W    = 16;
    localparam logic [15:0] TAP_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    typedef enum logic {
        MODE_GENERATE = 1'b0,
        MODE_COMPACT  = 1'b1
    } lfsr_mode_t;

    function automatic logic chan_fn(input logic a, input logic b,
                                     input logic c, input logic d);
        return (b | c | d) & ~(a & b);
    endfunction

endpackage

// File: rtl/gate_eval_bist_lfsr_misr16.sv
// 16-bit Fibonacci shift register (taps 16,14,13,11): pattern generator or signature compactor.
module lfsr_misr16
    import gate_eval_pkg::*;
#(
    parameter lfsr_mode_t        MODE    = MODE_GENERATE,
    parameter logic [SIG_W-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIG_W-1:0] load_val,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] q
);

    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] nxt;

    always_comb begin
        shifted = {q[SIG_W-2:0], ^(q & TAP_MASK)};
        nxt     = shifted ^ ((MODE == MODE_COMPACT) ? data : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/gate_eval_bist.sv
// Registered multi-channel gate cell with LFSR/MISR built-in self-test.
module gate_eval_bist
    import gate_eval_pkg::*;
#(
    parameter int unsigned CH     = 4,
    parameter int unsigned NPAT   = 32,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter logic [15:0] GOLDEN = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] one,
    input  logic [CH-1:0] two,
    input  logic [CH-1:0] three,
    input  logic [CH-1:0] four,
    output logic [CH-1:0] eight,
    input  logic          bist_start,
    input  logic          bist_abort,
    output logic          bist_busy,
    output logic          bist_done,
    output logic          bist_pass,
    output logic [15:0]   signature
);

    localparam logic [15:0] LAST = 16'(NPAT - 1);

    bist_state_t state, state_nxt;
    logic [15:0] cnt;
    logic [15:0] lfsr_q, misr_q, eight_ext;
    logic        active, launch, kill, lfsr_en, misr_en;

    always_comb begin
        active  = (state == RUN) || (state == FLUSH);
        // Abort outranks start; start is only honoured from IDLE or DONE.
        launch  = bist_start && !bist_abort && !active;
        kill    = bist_abort && active;
        lfsr_en = (state == RUN) && !bist_abort;
        // First RUN cycle still holds the pre-run response, so it is skipped.
        misr_en = (((state == RUN) && (cnt != 16'd0)) || (state == FLUSH)) && !bist_abort;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (launch) state_nxt = RUN;
            RUN: begin
                if (kill)             state_nxt = IDLE;
                else if (cnt == LAST) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = kill ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (launch)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + 16'd1;
        end
    end

    lfsr_misr16 #(
        .MODE    (MODE_GENERATE),
        .RST_VAL (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch),
        .load_val (SEED),
        .en       (lfsr_en),
        .data     ('0),
        .q        (lfsr_q)
    );

    always_comb begin
        eight_ext         = '0;
        eight_ext[CH-1:0] = eight;
    end

    lfsr_misr16 #(
        .MODE    (MODE_COMPACT),
        .RST_VAL ('0)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch),
        .load_val ('0),
        .en       (misr_en),
        .data     (eight_ext),
        .q        (misr_q)
    );

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam int unsigned BASE = (4 * i) % 16;
        logic a, b, c, d, q;

        always_comb begin
            if (state == RUN) begin
                a = lfsr_q[BASE];
                b = lfsr_q[BASE + 1];
                c = lfsr_q[BASE + 2];
                d = lfsr_q[BASE + 3];
            end else begin
                a = one[i];
                b = two[i];
                c = three[i];
                d = four[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= 1'b0;
            else if (state != FLUSH)
                q <= chan_fn(a, b, c, d);
        end

        assign eight[i] = q;
    end

    assign bist_busy = active;
    assign bist_done = (state == DONE);
    assign bist_pass = (state == DONE) && (misr_q == GOLDEN);
    assign signature = misr_q;

endmodule

// File: tb/tb_gate_eval_bist.sv
// Directed bench for gate_eval_bist: functional path, BIST run/fail/fault, reset and NPAT=1 edges.
module tb_gate_eval_bist;

    function automatic logic [15:0] ref_sig(input int ch, input int npat,
                                            input logic [15:0] seed,
                                            input logic [15:0] stuck0);
        logic [15:0] lf, ms, resp;
        logic a, b, c, d;
        lf = seed;
        ms = 16'h0000;
        for (int p = 0; p < npat; p++) begin
            resp = 16'h0000;
            for (int i = 0; i < ch; i++) begin
                a = lf[(4*i) % 16];
                b = lf[(4*i+1) % 16];
                c = lf[(4*i+2) % 16];
                d = lf[(4*i+3) % 16];
                resp[i] = (b | c | d) & ~(a & b);
            end
            resp = resp & ~stuck0;
            ms = {ms[14:0], ms[15] ^ ms[13] ^ ms[12] ^ ms[10]} ^ resp;
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
        return ms;
    endfunction

    localparam logic [15:0] SEED4  = 16'hACE1;
    localparam logic [15:0] SEED1  = 16'hACE2;
    localparam logic [15:0] GOLD4  = ref_sig(4, 32, SEED4, 16'h0000);
    localparam logic [15:0] FAULT4 = ref_sig(4, 32, SEED4, 16'h0004);
    localparam logic [15:0] GOLD1  = ref_sig(1, 1, SEED1, 16'h0000);

    logic clk, rst_n;
    logic [3:0] one4, two4, three4, four4, eight_a, eight_f;
    logic start4, abort4;
    logic busy_a, done_a, pass_a, busy_f, done_f, pass_f;
    logic [15:0] sig_a, sig_f, sig_1;
    logic [0:0] one1, two1, three1, four1, eight_1;
    logic start1, abort1, busy_1, done_1, pass_1;

    int n_checks = 0;
    int n_fail   = 0;

    gate_eval_bist #(.CH(4), .NPAT(32), .SEED(SEED4), .GOLDEN(GOLD4)) dut_a (
        .clk(clk), .rst_n(rst_n), .one(one4), .two(two4), .three(three4), .four(four4),
        .eight(eight_a), .bist_start(start4), .bist_abort(abort4), .bist_busy(busy_a),
        .bist_done(done_a), .bist_pass(pass_a), .signature(sig_a));

    gate_eval_bist #(.CH(4), .NPAT(32), .SEED(SEED4), .GOLDEN(GOLD4 ^ 16'h0001)) dut_f (
        .clk(clk), .rst_n(rst_n), .one(one4), .two(two4), .three(three4), .four(four4),
        .eight(eight_f), .bist_start(start4), .bist_abort(abort4), .bist_busy(busy_f),
        .bist_done(done_f), .bist_pass(pass_f), .signature(sig_f));

    gate_eval_bist #(.CH(1), .NPAT(1), .SEED(SEED1), .GOLDEN(GOLD1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .one(one1), .two(two1), .three(three1), .four(four1),
        .eight(eight_1), .bist_start(start1), .bist_abort(abort1), .bist_busy(busy_1),
        .bist_done(done_1), .bist_pass(pass_1), .signature(sig_1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {one4, two4, three4, four4, start4, abort4} = '0;
        {one1, two1, three1, four1, start1, abort1} = '0;
        #3;
        n_checks++;
        if (eight_a !== 4'h0 || eight_f !== 4'h0 || eight_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_eight: got %h/%h/%h expected 0", eight_a, eight_f, eight_1);
        end
        n_checks++;
        if ({busy_a, done_a, pass_a, busy_1, done_1, pass_1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy_a, done_a, pass_a, busy_1, done_1, pass_1});
        end
        n_checks++;
        if (sig_a !== 16'h0000 || sig_1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_sig: got %h/%h expected 0000", sig_a, sig_1);
        end
        #14 rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_functional();
        logic [3:0] vec [7];
        logic       exp [7];
        vec = '{4'b1111, 4'b0111, 4'b1101, 4'b1011, 4'b0000, 4'b1001, 4'b0011};
        exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            one1 = vec[k][3]; two1 = vec[k][2]; three1 = vec[k][1]; four1 = vec[k][0];
            tick();
            n_checks++;
            if (eight_1 !== exp[k]) begin
                n_fail++;
                $display("FAIL func_vec%0d: abcd=%b got %b expected %b", k, vec[k], eight_1, exp[k]);
            end
        end
        // ch0..ch3 = abcd 1111, 0111, 1101, 1011
        one4 = 4'b1101; two4 = 4'b0111; three4 = 4'b1011; four4 = 4'b1111;
        tick();
        n_checks++;
        if (eight_a !== 4'b1010) begin
            n_fail++;
            $display("FAIL func_ch4: got %b expected 1010", eight_a);
        end
    endtask

    task automatic test_start_abort_idle();
        start1 = 1'b1; abort1 = 1'b1;
        tick();
        start1 = 1'b0; abort1 = 1'b0;
        n_checks++;
        if (busy_1 !== 1'b0 || done_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b done=%b expected 0 0", busy_1, done_1);
        end
        tick();
        n_checks++;
        if (busy_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_late: busy=%b expected 0", busy_1);
        end
    endtask

    task automatic run1(input string tag);
        int edge_n;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        edge_n = 0;
        n_checks++;
        if (busy_1 !== 1'b1 || done_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_run_entry: busy=%b done=%b expected 1 0", tag, busy_1, done_1);
        end
        while (busy_1 === 1'b1 && edge_n < 50) begin
            tick();
            edge_n++;
        end
        n_checks++;
        if (edge_n != 2 || done_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_edge: edge=%0d done=%b expected 2 1", tag, edge_n, done_1);
        end
        n_checks++;
        if (pass_1 !== 1'b1 || sig_1 !== GOLD1) begin
            n_fail++;
            $display("FAIL %s_sig: pass=%b sig=%h expected 1 %h", tag, pass_1, sig_1, GOLD1);
        end
    endtask

    task automatic test_npat1_done();
        run1("npat1");
        one1 = 1'b0; two1 = 1'b1; three1 = 1'b1; four1 = 1'b0;
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        tick();
        n_checks++;
        if (sig_1 !== GOLD1 || done_1 !== 1'b1 || eight_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: sig=%h done=%b eight=%b expected %h 1 1",
                     sig_1, done_1, eight_1, GOLD1);
        end
    endtask

    task automatic test_restart_done();
        run1("restart");
    endtask

    task automatic test_abort_flush();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        n_checks++;
        if (busy_1 !== 1'b1 || done_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: busy=%b done=%b expected 1 0", busy_1, done_1);
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        n_checks++;
        if ({busy_1, done_1, pass_1} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_flush: busy/done/pass=%b expected 000", {busy_1, done_1, pass_1});
        end
        tick();
        n_checks++;
        if (done_1 !== 1'b0 || busy_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: busy=%b done=%b expected 0 0", busy_1, done_1);
        end
    endtask

    task automatic run4(input string tag, input logic [15:0] exp_sig, input logic exp_pass);
        int edge_n;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        edge_n = 0;
        n_checks++;
        if (busy_a !== 1'b1 || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_run_entry: busy=%b pass=%b expected 1 0", tag, busy_a, pass_a);
        end
        while (busy_a === 1'b1 && edge_n < 200) begin
            tick();
            edge_n++;
        end
        n_checks++;
        if (edge_n != 33 || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_len: busy_cycles=%0d done=%b expected 33 1", tag, edge_n, done_a);
        end
        n_checks++;
        if (sig_a !== exp_sig || pass_a !== exp_pass) begin
            n_fail++;
            $display("FAIL %s_sig: sig=%h pass=%b expected %h %b", tag, sig_a, pass_a, exp_sig, exp_pass);
        end
    endtask

    task automatic test_bist_pass();
        run4("pass", GOLD4, 1'b1);
        n_checks++;
        if (done_f !== 1'b1 || pass_f !== 1'b0 || sig_f !== GOLD4) begin
            n_fail++;
            $display("FAIL bad_golden: done=%b pass=%b sig=%h expected 1 0 %h",
                     done_f, pass_f, sig_f, GOLD4);
        end
    endtask

    task automatic test_reset_midrun();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (eight_a !== 4'h0 || busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_midrun: eight=%h busy=%b done=%b sig=%h expected 0 0 0 0000",
                     eight_a, busy_a, done_a, sig_a);
        end
        #2 rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun_idle: busy=%b done=%b expected 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_fault();
        force dut_a.g_ch[2].q = 1'b0;
        run4("fault", FAULT4, 1'b0);
        release dut_a.g_ch[2].q;
    endtask

    initial begin
        test_reset();
        test_functional();
        test_start_abort_idle();
        test_npat1_done();
        test_restart_done();
        test_abort_flush();
        test_bist_pass();
        test_reset_midrun();
        test_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
